// File: rtl/satd_block_loader.sv
// satd_block_loader: assembles 64-bit ORG/CUR rows into 16-row SATD blocks.
// Define DOUBLE_BUF_EN for ping-pong banking with back-to-back blocks.
module satd_block_loader #(
   parameter int ROWS  = 16,
   parameter int ROW_W = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     row_valid,
   output logic                     row_ready,
   input  logic [ROW_W-1:0]         ORG_ROW,
   input  logic [ROW_W-1:0]         CUR_ROW,
   input  logic                     row_last,
   output logic                     blk_valid,
   input  logic                     blk_ready,
   output logic [ROWS*ROW_W-1:0]    ORG,
   output logic [ROWS*ROW_W-1:0]    CUR,
   output logic [$clog2(ROWS)-1:0]  row_count,
   output logic                     err_last
);
   localparam int CW = $clog2(ROWS);
   localparam int BW = ROWS * ROW_W;
   localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

   logic          accept;
   logic          is_last;
   logic [CW-1:0] row_count_q, row_count_d;
   logic          err_last_q, err_last_d;

   assign accept    = row_valid && row_ready;
   assign is_last   = (row_count_q == LAST);
   assign row_count = row_count_q;
   assign err_last  = err_last_q;

   // row_last is advisory: framing is driven purely by row_count
   always_comb begin
      row_count_d = row_count_q;
      err_last_d  = 1'b0;
      if (accept) begin
         row_count_d = is_last ? '0 : row_count_q + 1'b1;
         err_last_d  = (row_last != is_last);
      end
   end

`ifdef DOUBLE_BUF_EN
   logic [BW-1:0] org_q [2];
   logic [BW-1:0] cur_q [2];
   logic [1:0]    full_q, full_d;
   logic          wr_sel_q;
   logic          rd_sel_q;
   logic          hs;

   assign hs        = full_q[rd_sel_q] && blk_ready;
   assign row_ready = !full_q[wr_sel_q] && !rst;
   assign blk_valid = full_q[rd_sel_q];
   assign ORG       = org_q[rd_sel_q];
   assign CUR       = cur_q[rd_sel_q];

   // set and clear always target different banks
   always_comb begin
      full_d = full_q;
      if (accept && is_last) full_d[wr_sel_q] = 1'b1;
      if (hs)                full_d[rd_sel_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         org_q[0]    <= '0;
         org_q[1]    <= '0;
         cur_q[0]    <= '0;
         cur_q[1]    <= '0;
         full_q      <= '0;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         row_count_q <= '0;
         err_last_q  <= 1'b0;
      end else begin
         row_count_q <= row_count_d;
         err_last_q  <= err_last_d;
         full_q      <= full_d;
         if (accept) begin
            org_q[wr_sel_q][row_count_q*ROW_W +: ROW_W] <= ORG_ROW;
            cur_q[wr_sel_q][row_count_q*ROW_W +: ROW_W] <= CUR_ROW;
         end
         if (accept && is_last) wr_sel_q <= !wr_sel_q;
         if (hs)                rd_sel_q <= !rd_sel_q;
      end
   end
`else
   typedef enum logic {FILL, FULL} state_t;

   state_t        state_q;
   logic [BW-1:0] org_q;
   logic [BW-1:0] cur_q;
   logic          blk_valid_q;

   assign row_ready = (state_q == FILL) && !rst;
   assign blk_valid = blk_valid_q;
   assign ORG       = org_q;
   assign CUR       = cur_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         org_q       <= '0;
         cur_q       <= '0;
         blk_valid_q <= 1'b0;
         row_count_q <= '0;
         err_last_q  <= 1'b0;
      end else begin
         row_count_q <= row_count_d;
         err_last_q  <= err_last_d;
         if (accept) begin
            org_q[row_count_q*ROW_W +: ROW_W] <= ORG_ROW;
            cur_q[row_count_q*ROW_W +: ROW_W] <= CUR_ROW;
         end
         unique case (state_q)
            FILL: begin
               if (accept && is_last) begin
                  state_q     <= FULL;
                  blk_valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (blk_ready) begin
                  state_q     <= FILL;
                  blk_valid_q <= 1'b0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_satd_block_loader.sv
// Scoreboard bench for satd_block_loader: rows queued on accept,
// whole blocks popped and compared when presented.
module tb_satd_block_loader;
   localparam int ROWS  = 16;
   localparam int ROW_W = 64;
   localparam int BW    = ROWS * ROW_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             row_valid = 1'b0;
   logic             row_last = 1'b0;
   logic             blk_ready = 1'b0;
   logic [ROW_W-1:0] ORG_ROW = '0;
   logic [ROW_W-1:0] CUR_ROW = '0;
   logic             row_ready;
   logic             blk_valid;
   logic             err_last;
   logic [BW-1:0]    ORG;
   logic [BW-1:0]    CUR;
   logic [3:0]       row_count;

   int n_checks = 0;
   int n_pass = 0;
   logic [ROW_W-1:0] q_org [$];
   logic [ROW_W-1:0] q_cur [$];
   logic [BW-1:0]    zero_blk = '0;

   always #5 clk = ~clk;

   satd_block_loader dut (
      .clk       (clk),
      .rst       (rst),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .ORG_ROW   (ORG_ROW),
      .CUR_ROW   (CUR_ROW),
      .row_last  (row_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .ORG       (ORG),
      .CUR       (CUR),
      .row_count (row_count),
      .err_last  (err_last)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ROW_W-1:0] pat(input int r);
      logic [7:0] b;
      b = r[7:0];
      return {8{b}};
   endfunction

   function automatic int bad_row(input logic [BW-1:0] eo, input logic [BW-1:0] ec);
      for (int r = 0; r < ROWS; r++)
         if (ORG[r*ROW_W +: ROW_W] !== eo[r*ROW_W +: ROW_W] ||
             CUR[r*ROW_W +: ROW_W] !== ec[r*ROW_W +: ROW_W])
            return r;
      return 0;
   endfunction

   task automatic send_row(input logic [ROW_W-1:0] o, input logic [ROW_W-1:0] c,
                           input logic last);
      int t = 0;
      row_valid = 1'b1;
      ORG_ROW   = o;
      CUR_ROW   = c;
      row_last  = last;
      while (!row_ready && t < 200) begin
         step();
         t++;
      end
      if (!row_ready) begin
         n_checks++;
         $display("FAIL send_row_timeout row_ready=%b required 1", row_ready);
      end else begin
         q_org.push_back(o);
         q_cur.push_back(c);
         step();
      end
      row_valid = 1'b0;
      row_last  = 1'b0;
   endtask

   task automatic wait_blk(output bit ok);
      int t = 0;
      while (!blk_valid && t < 100) begin
         step();
         t++;
      end
      ok = blk_valid;
   endtask

   task automatic pop_block(output logic [BW-1:0] eo, output logic [BW-1:0] ec);
      eo = '0;
      ec = '0;
      for (int r = 0; r < ROWS; r++)
         if (q_org.size() != 0) begin
            eo[r*ROW_W +: ROW_W] = q_org.pop_front();
            ec[r*ROW_W +: ROW_W] = q_cur.pop_front();
         end
   endtask

   task automatic release_blk();
      blk_ready = 1'b1;
      step();
      blk_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if (row_ready !== 1'b0) $display("FAIL rst_row_ready got %b required 0", row_ready);
      else n_pass++;
      n_checks++;
      if (blk_valid !== 1'b0) $display("FAIL rst_blk_valid got %b required 0", blk_valid);
      else n_pass++;
      n_checks++;
      if (ORG !== zero_blk) $display("FAIL rst_org got nonzero required 0");
      else n_pass++;
      n_checks++;
      if (CUR !== zero_blk) $display("FAIL rst_cur got nonzero required 0");
      else n_pass++;
      n_checks++;
      if (row_count !== 4'd0) $display("FAIL rst_row_count got %0d required 0", row_count);
      else n_pass++;
      n_checks++;
      if (err_last !== 1'b0) $display("FAIL rst_err_last got %b required 0", err_last);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (row_ready !== 1'b1) $display("FAIL post_rst_row_ready got %b required 1", row_ready);
      else n_pass++;
   endtask

   task automatic test_fill();
      logic [BW-1:0] eo, ec;
      bit ok;
      int r;
      for (int i = 0; i < ROWS; i++) begin
         if (i == ROWS - 1) begin
            n_checks++;
            if (blk_valid !== 1'b0) $display("FAIL fill_early_valid got %b required 0", blk_valid);
            else n_pass++;
         end
         send_row(pat(i), ~pat(i), i == ROWS - 1);
      end
      n_checks++;
      if (blk_valid !== 1'b1) $display("FAIL fill_latency blk_valid got %b required 1", blk_valid);
      else n_pass++;
      n_checks++;
      if (row_count !== 4'd0) $display("FAIL fill_row_count got %0d required 0", row_count);
      else n_pass++;
      n_checks++;
      if (ORG[3*ROW_W +: ROW_W] !== pat(3))
         $display("FAIL fill_row3 got %h required %h", ORG[3*ROW_W +: ROW_W], pat(3));
      else n_pass++;
      wait_blk(ok);
      pop_block(eo, ec);
      n_checks++;
      if (!ok || ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL fill_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
      n_checks++;
      if (blk_valid !== 1'b0) $display("FAIL fill_release blk_valid got %b required 0", blk_valid);
      else n_pass++;
      n_checks++;
      if (row_ready !== 1'b1) $display("FAIL fill_resume row_ready got %b required 1", row_ready);
      else n_pass++;
   endtask

   task automatic test_stall();
      logic [BW-1:0] eo, ec;
      logic [ROW_W-1:0] d0o, d0c;
      bit rr_bad = 0;
      bit bv_bad = 0;
      bit ok;
      int r;
      for (int i = 0; i < ROWS; i++)
         send_row({$urandom, $urandom}, {$urandom, $urandom}, i == ROWS - 1);
      d0o = {$urandom, $urandom};
      d0c = {$urandom, $urandom};
      row_valid = 1'b1;
      ORG_ROW   = d0o;
      CUR_ROW   = d0c;
      for (int i = 0; i < 10; i++) begin
         if (row_ready !== 1'b0) rr_bad = 1;
         if (blk_valid !== 1'b1) bv_bad = 1;
         step();
      end
      n_checks++;
      if (rr_bad || bv_bad)
         $display("FAIL stall_hold row_ready_bad=%b blk_valid_bad=%b required 0 0", rr_bad, bv_bad);
      else n_pass++;
      pop_block(eo, ec);
      n_checks++;
      if (ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL stall_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
      n_checks++;
      if (blk_valid !== 1'b0) $display("FAIL stall_release blk_valid got %b required 0", blk_valid);
      else n_pass++;
      n_checks++;
      if (row_ready !== 1'b1) $display("FAIL stall_resume row_ready got %b required 1", row_ready);
      else n_pass++;
      send_row(d0o, d0c, 1'b0);
      for (int i = 1; i < ROWS; i++)
         send_row({$urandom, $urandom}, {$urandom, $urandom}, i == ROWS - 1);
      wait_blk(ok);
      pop_block(eo, ec);
      n_checks++;
      if (!ok || ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL stall_no_loss row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
   endtask

   task automatic test_toggle();
      logic [BW-1:0] eo, ec;
      bit ok;
      int r;
      int acc = 0;
      for (int i = 0; i < 2 * ROWS; i++) begin
         row_valid = (i % 2 == 0);
         ORG_ROW   = {$urandom, $urandom};
         CUR_ROW   = {$urandom, $urandom};
         row_last  = (acc == ROWS - 1);
         if (row_valid && row_ready) begin
            q_org.push_back(ORG_ROW);
            q_cur.push_back(CUR_ROW);
            acc++;
         end
         step();
      end
      row_valid = 1'b0;
      row_last  = 1'b0;
      wait_blk(ok);
      pop_block(eo, ec);
      n_checks++;
      if (!ok || ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL toggle_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
   endtask

   task automatic test_last_err();
      logic [BW-1:0] eo, ec;
      logic [15:0] errs = '0;
      bit ok;
      int r;
      for (int i = 0; i < ROWS; i++) begin
         send_row(pat(i + 32), ~pat(i + 32), i == 5);
         errs[i] = err_last;
      end
      n_checks++;
      if (errs !== 16'h8020) $display("FAIL err_last_rows got %h required 8020", errs);
      else n_pass++;
      n_checks++;
      if (blk_valid !== 1'b1) $display("FAIL err_block_done blk_valid got %b required 1", blk_valid);
      else n_pass++;
      step();
      n_checks++;
      if (err_last !== 1'b0) $display("FAIL err_pulse got %b required 0", err_last);
      else n_pass++;
      wait_blk(ok);
      pop_block(eo, ec);
      n_checks++;
      if (!ok || ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL err_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
   endtask

   task automatic test_midreset();
      logic [BW-1:0] eo, ec;
      bit ok;
      int r;
      for (int i = 0; i < 8; i++)
         send_row({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      rst = 1'b1;
      #1;
      n_checks++;
      if (row_ready !== 1'b0) $display("FAIL midrst_row_ready got %b required 0", row_ready);
      else n_pass++;
      step();
      rst = 1'b0;
      q_org.delete();
      q_cur.delete();
      n_checks++;
      if (blk_valid !== 1'b0) $display("FAIL midrst_blk_valid got %b required 0", blk_valid);
      else n_pass++;
      n_checks++;
      if (row_count !== 4'd0) $display("FAIL midrst_row_count got %0d required 0", row_count);
      else n_pass++;
      n_checks++;
      if (ORG !== zero_blk) $display("FAIL midrst_org got nonzero required 0");
      else n_pass++;
      step();
      for (int i = 0; i < ROWS; i++)
         send_row({$urandom, $urandom}, {$urandom, $urandom}, i == ROWS - 1);
      wait_blk(ok);
      pop_block(eo, ec);
      n_checks++;
      if (!ok || ORG !== eo || CUR !== ec) begin
         r = bad_row(eo, ec);
         $display("FAIL midrst_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                  ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                  eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
      end else n_pass++;
      release_blk();
   endtask

`ifdef DOUBLE_BUF_EN
   task automatic test_back_to_back();
      logic [BW-1:0] eo, ec;
      int last_hs = -1;
      int cnt = 0;
      int r;
      bit seen = 0;
      bit rr_bad = 0;
      row_valid = 1'b1;
      blk_ready = 1'b1;
      for (int i = 0; i < 5 * ROWS; i++) begin
         ORG_ROW  = {$urandom, $urandom};
         CUR_ROW  = {$urandom, $urandom};
         row_last = (cnt == ROWS - 1);
         if (seen && !row_ready) rr_bad = 1;
         if (blk_valid) begin
            pop_block(eo, ec);
            n_checks++;
            if (ORG !== eo || CUR !== ec) begin
               r = bad_row(eo, ec);
               $display("FAIL b2b_block row %0d ORG=%h CUR=%h required ORG=%h CUR=%h", r,
                        ORG[r*ROW_W +: ROW_W], CUR[r*ROW_W +: ROW_W],
                        eo[r*ROW_W +: ROW_W], ec[r*ROW_W +: ROW_W]);
            end else n_pass++;
            if (last_hs >= 0) begin
               n_checks++;
               if (i - last_hs !== ROWS)
                  $display("FAIL b2b_gap got %0d required %0d", i - last_hs, ROWS);
               else n_pass++;
            end
            last_hs = i;
            seen = 1;
         end
         if (row_valid && row_ready) begin
            q_org.push_back(ORG_ROW);
            q_cur.push_back(CUR_ROW);
            cnt = (cnt + 1) % ROWS;
         end
         step();
      end
      row_valid = 1'b0;
      blk_ready = 1'b0;
      row_last  = 1'b0;
      n_checks++;
      if (rr_bad || !seen) $display("FAIL b2b_row_ready dropped=%b seen=%b required 0 1", rr_bad, seen);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
`ifndef DOUBLE_BUF_EN
      test_stall();
`endif
      test_toggle();
      test_last_err();
      test_midreset();
`ifdef DOUBLE_BUF_EN
      test_back_to_back();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
